// File: rtl/dac_mapping_if.sv
// dac_mapping_if: CSR write/readback and logical/physical sample buses of the
// DAC channel mapper. The master drives writes and logical samples; the slave
// (the mapper) drives readback and the physical samples.
interface dac_mapping_if #(
  parameter int DAC_NUM_CHANNELS = 8,
  parameter int DAC_WIDTH        = 16
);
  logic                                  csrStrobe;
  logic [31:0]                           GPIO_OUT;
  logic [31:0]                           csr;
  logic                                  dacSync;
  logic [DAC_NUM_CHANNELS*DAC_WIDTH-1:0] dacLogicalData;
  logic [DAC_NUM_CHANNELS-1:0]           dacLogicalValid;
  logic [DAC_NUM_CHANNELS*DAC_WIDTH-1:0] dacPhysicalData;
  logic [DAC_NUM_CHANNELS-1:0]           dacPhysicalValid;

  modport master (
    output csrStrobe, GPIO_OUT, dacSync, dacLogicalData, dacLogicalValid,
    input  csr, dacPhysicalData, dacPhysicalValid
  );

  modport slave (
    input  csrStrobe, GPIO_OUT, dacSync, dacLogicalData, dacLogicalValid,
    output csr, dacPhysicalData, dacPhysicalValid
  );
endinterface

// File: rtl/dac_mapping.sv
// dac_mapping: routes logical DAC channels to physical DAC outputs.
// A map written through the CSR path is checked to be a permutation, held
// pending and swapped in atomically on dacSync.
// Optional feature macro: DAC_MAPPING_MUTE_EN -- when defined, outputs are
// forced to zero/invalid for MUTE_CYCLES samples after each switch.
module dac_mapping #(
  parameter int DAC_NUM_CHANNELS = 8,
  parameter int DAC_WIDTH        = 16,
  parameter int MUTE_CYCLES      = 4
) (
  input  logic          dacClk,
  input  logic          dacReset,
  dac_mapping_if.slave  bus
);
  localparam int N = DAC_NUM_CHANNELS;
  localparam int W = DAC_WIDTH;
  localparam logic [23:0] IDENTITY_MAP = 24'hFAC688;

  if (DAC_NUM_CHANNELS < 1 || DAC_NUM_CHANNELS > 8) begin : g_bad_channels
    $error("dac_mapping: DAC_NUM_CHANNELS must be in 1..8");
  end
  if (MUTE_CYCLES < 0 || MUTE_CYCLES > 255) begin : g_bad_mute
    $error("dac_mapping: MUTE_CYCLES must be in 0..255");
  end

  // A map is usable when each checked field names an existing output and no
  // two checked fields share a destination; fields >= N are not examined.
  function automatic logic map_is_valid(input logic [23:0] map);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < N; i++) begin
      ok = ok & ({1'b0, map[i*3 +: 3]} < 4'(N));
      for (int j = 0; j < i; j++) begin
        ok = ok & (map[i*3 +: 3] != map[j*3 +: 3]);
      end
    end
    return ok;
  endfunction

  logic [23:0]      active_map_q, active_map_d;
  logic [23:0]      pending_map_q, pending_map_d;
  logic             pending_q, pending_d;
  logic             error_q, error_d;
  logic [N*W-1:0]   phys_data_q;
  logic [N-1:0]     phys_valid_q;
  logic [N*W-1:0]   route_data_s;
  logic [N-1:0]     route_valid_s;
  logic             wr_valid_s;
  logic             switch_s;
  logic             mute_active_s;
  logic [7:0]       gpio_unused_s;

  assign gpio_unused_s = bus.GPIO_OUT[31:24];
  assign wr_valid_s    = map_is_valid(bus.GPIO_OUT[23:0]);
  assign switch_s      = pending_q & bus.dacSync & ~mute_active_s;

`ifdef DAC_MAPPING_MUTE_EN
  typedef enum logic {ST_RUN = 1'b0, ST_MUTE = 1'b1} state_t;
  state_t     state_q;
  logic [7:0] mute_cnt_q;

  // Mute FSM: enter MUTE on a switch, count down, and return to RUN at 1.
  always_ff @(posedge dacClk) begin
    if (dacReset) begin
      state_q    <= ST_RUN;
      mute_cnt_q <= 8'd0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (switch_s && (MUTE_CYCLES > 0)) begin
            state_q    <= ST_MUTE;
            mute_cnt_q <= 8'(MUTE_CYCLES);
          end else begin
            state_q    <= ST_RUN;
            mute_cnt_q <= mute_cnt_q;
          end
        end
        ST_MUTE: begin
          if (mute_cnt_q <= 8'd1) begin
            state_q    <= ST_RUN;
            mute_cnt_q <= 8'd0;
          end else begin
            state_q    <= ST_MUTE;
            mute_cnt_q <= mute_cnt_q - 8'd1;
          end
        end
        default: begin
          state_q    <= ST_RUN;
          mute_cnt_q <= 8'd0;
        end
      endcase
    end
  end

  assign mute_active_s = (state_q == ST_MUTE);
`else
  assign mute_active_s = 1'b0;
`endif

  // Map registers next state: the switch consumes the old pending map, then a
  // valid write in the same cycle installs the new pending map on top.
  always_comb begin
    active_map_d  = active_map_q;
    pending_map_d = pending_map_q;
    pending_d     = pending_q;
    error_d       = error_q;
    if (switch_s) begin
      active_map_d = pending_map_q;
      pending_d    = 1'b0;
    end else begin
      active_map_d = active_map_q;
    end
    if (bus.csrStrobe) begin
      if (wr_valid_s) begin
        pending_map_d = bus.GPIO_OUT[23:0];
        pending_d     = 1'b1;
        error_d       = 1'b0;
      end else begin
        error_d       = 1'b1;
      end
    end else begin
      error_d = error_q;
    end
  end

  // Map state registers.
  always_ff @(posedge dacClk) begin
    if (dacReset) begin
      active_map_q  <= IDENTITY_MAP;
      pending_map_q <= IDENTITY_MAP;
      pending_q     <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      active_map_q  <= active_map_d;
      pending_map_q <= pending_map_d;
      pending_q     <= pending_d;
      error_q       <= error_d;
    end
  end

  // Crossbar: output p collects the one logical channel whose field equals p;
  // OR-accumulation is exact because a permutation yields a single hit.
  always_comb begin
    route_data_s  = '0;
    route_valid_s = '0;
    for (int p = 0; p < N; p++) begin
      for (int i = 0; i < N; i++) begin
        route_data_s[p*W +: W] = route_data_s[p*W +: W] |
          ({W{active_map_q[i*3 +: 3] == 3'(p)}} & bus.dacLogicalData[i*W +: W]);
        route_valid_s[p] = route_valid_s[p] |
          ((active_map_q[i*3 +: 3] == 3'(p)) & bus.dacLogicalValid[i]);
      end
    end
  end

  // Registered physical outputs, zeroed while muting.
  always_ff @(posedge dacClk) begin
    if (dacReset) begin
      phys_data_q  <= '0;
      phys_valid_q <= '0;
    end else if (mute_active_s) begin
      phys_data_q  <= '0;
      phys_valid_q <= '0;
    end else begin
      phys_data_q  <= route_data_s;
      phys_valid_q <= route_valid_s;
    end
  end

  assign bus.dacPhysicalData  = phys_data_q;
  assign bus.dacPhysicalValid = phys_valid_q;
  assign bus.csr = {5'b00000, mute_active_s, error_q, pending_q, active_map_q};
endmodule

// File: doc/dac_mapping.md
# dac_mapping

Routes logical DAC channels to physical DAC outputs on the DAC clock, the transmit-side counterpart of the ADC physical-to-logical channel map. Software writes a new map through the GPIO CSR path; the block validates it as a permutation, holds it pending, and swaps it in atomically on a frame-sync pulse, optionally muting outputs for a fixed number of samples around the switchover. It sits between the logical DAC waveform generators and the physical DAC serializer interface.

## Interface
- DAC_NUM_CHANNELS, 8: channels routed; must be 1..8, larger values fail elaboration.
- DAC_WIDTH, 16: sample width in bits.
- MUTE_CYCLES, 4: samples forced to zero after a switch; range 0..255.

- dacClk  input  1  sole clock; all inputs are synchronous to it.
- dacReset  input  1  synchronous, active-high reset.
- csrStrobe  input  1  one-cycle write strobe for the map register.
- GPIO_OUT  input  32  write data; bits [23:0] hold eight 3-bit fields; field i is the physical destination of logical channel i; bits [31:24] are ignored.
- csr  output  32  status/readback, see Operation.
- dacSync  input  1  frame-boundary pulse; a pending map is applied only here.
- dacLogicalData  input  DAC_NUM_CHANNELS*DAC_WIDTH  logical samples, channel i at [i*DAC_WIDTH +: DAC_WIDTH].
- dacLogicalValid  input  DAC_NUM_CHANNELS  per-channel valid.
- dacPhysicalData  output  DAC_NUM_CHANNELS*DAC_WIDTH  registered physical samples.
- dacPhysicalValid  output  DAC_NUM_CHANNELS  registered per-channel valid.

## Operation
- Registers: activeMap[23:0], pendingMap[23:0], pending flag, error flag, state {RUN, MUTE}, muteCount[7:0].
- Reset: activeMap = identity (field i = i), pendingMap = identity, pending = 0, error = 0, state = RUN, muteCount = 0, dacPhysicalData = 0, dacPhysicalValid = 0.
- Validity: only fields 0..DAC_NUM_CHANNELS-1 are checked; valid if every field < DAC_NUM_CHANNELS and no two fields are equal. Fields above DAC_NUM_CHANNELS-1 are ignored and stored as written.
- csrStrobe, valid map: pendingMap <= GPIO_OUT[23:0], pending <= 1, error <= 0. Accepted in any state; it overwrites an earlier pending map.
- csrStrobe, invalid map: pendingMap and pending are unchanged; error <= 1. error stays set until the next valid write or reset.
- Switch: in RUN with pending = 1 and dacSync = 1: activeMap <= pendingMap, pending <= 0. With the mute feature and MUTE_CYCLES > 0: muteCount <= MUTE_CYCLES and state <= MUTE. Otherwise state stays RUN.
- dacSync with pending = 0, or while in MUTE, is ignored.
- csrStrobe and dacSync in the same cycle: the switch uses the pendingMap value from before that edge. The strobe's valid map then becomes the new pending map with pending = 1.
- MUTE: muteCount decrements each cycle; at muteCount == 1 the state returns to RUN.
- Datapath, RUN: for each physical output p, the output takes the logical channel i whose activeMap field equals p. A permutation guarantees exactly one source per output.
- Datapath, MUTE: all outputs are forced to data 0 and valid 0.
- csr readback: [23:0] activeMap, [24] pending, [25] error, [26] state == MUTE, [31:27] 0.

## Timing
- Datapath latency: 1 cycle, from logical input to registered physical output.
- On the switch edge, the registered output still uses the old map.
- With mute: the next MUTE_CYCLES output samples are zero and invalid; the sample after them uses the new map.
- Without mute: the output on the cycle after the switch edge uses the new map.
- csr reflects a write on the cycle after csrStrobe.
- dacReset during MUTE or with a map pending returns to the reset state at the next edge; the pending map is discarded.

## Configuration
- DAC_MAPPING_MUTE_EN defined: MUTE state, muteCount and the mute output gating are compiled in.
- DAC_MAPPING_MUTE_EN undefined: MUTE_CYCLES is ignored and the state is always RUN. A switch takes effect directly, csr[26] reads 0, and no mute logic is built.

## Test plan
- Reset, DAC_NUM_CHANNELS = 8, logical channel i data = 0x1000+i, all valid -> physical p = 0x1000+p, csr = 0x00FAC688 (identity map).
- Write map swapping channels 0 and 1 (GPIO_OUT = 0x00FAC681), then dacSync -> csr[24] = 1 until the sync. Afterwards physical 0 = 0x1001, physical 1 = 0x1000; with DAC_MAPPING_MUTE_EN and MUTE_CYCLES = 4, exactly 4 zero/invalid samples precede the swap.
- Write a duplicate map (fields 0 and 1 both 0) -> csr[25] = 1, activeMap and pending unchanged. A following valid write clears csr[25].
- csrStrobe with map B on the same cycle as dacSync with map A pending -> A becomes active, csr[24] = 1, and B is applied at the next dacSync.
- dacSync during MUTE with a new map pending -> ignored; the map is applied at the first dacSync after the return to RUN.
- Assert dacReset mid-mute -> next cycle: outputs 0, csr = 0x00FAC688, csr[26] = 0.
